// File: rtl/arbiter_rr.sv
// Round-robin arbiter with a grant quantum: N stb/rdy requesters share one
// registered downstream stage, each beat tagged with its source index.
module arbiter_rr #(
  parameter int W = 8,
  parameter int N = 2,
  parameter int Q = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           s_stb,
  input  logic [N*W-1:0]         s_dat,
  output logic [N-1:0]           s_rdy,
  input  logic                   m_rdy,
  output logic                   m_stb,
  output logic [$clog2(N)+W-1:0] m_dat
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(Q+1);

  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic            r_m_stb;
  logic [IW+W-1:0] r_m_dat;

  logic            w_lock;
  logic            w_valid;
  logic            w_open;
  logic            w_accept;
  logic [IW-1:0]   w_sel;
  logic [W-1:0]    w_sel_dat;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= N) t = t - N;
    return IW'(t);
  endfunction

  assign w_lock   = s_stb[r_owner] & (r_cnt != '0) & (r_cnt < CW'(Q));
  assign w_valid  = |s_stb;
  assign w_open   = ~r_m_stb | m_rdy;
  assign w_accept = w_valid & w_open;

  // Scan farthest-first so the nearest requester after the owner wins;
  // k = N lands on the owner itself, giving it the lowest priority.
  always_comb begin
    w_sel = r_owner;
    if (!w_lock) begin
      for (int k = N; k >= 1; k--) begin
        if (s_stb[wrap_idx(r_owner, k)]) w_sel = wrap_idx(r_owner, k);
      end
    end
  end

  assign w_sel_dat = s_dat[int'(w_sel)*W +: W];

  always_comb begin
    s_rdy = '0;
    if (w_accept && !rst) s_rdy[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_stb <= 1'b0;
      r_m_dat <= '0;
      r_owner <= IW'(N-1);
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_m_stb <= 1'b1;
      r_m_dat <= {w_sel, w_sel_dat};
      if (w_lock) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_owner <= w_sel;
        r_cnt   <= CW'(1);
      end
    end else if (m_rdy) begin
      r_m_stb <= 1'b0;
    end
  end

  assign m_stb = r_m_stb;
  assign m_dat = r_m_dat;

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr: vector tables on three configurations, an async
// reset sequence, and randomized traffic against a behavioural model.
module tb_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  stb;
  logic [31:0] dat;
  logic        m_rdy;

  logic [3:0]  srdy_a, srdy_c;
  logic [2:0]  srdy_b;
  logic        mstb_a, mstb_b, mstb_c;
  logic [9:0]  mdat_a, mdat_b, mdat_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arbiter_rr #(.W(8), .N(4), .Q(2)) dut_a (
    .clk(clk), .rst(rst), .s_stb(stb), .s_dat(dat), .s_rdy(srdy_a),
    .m_rdy(m_rdy), .m_stb(mstb_a), .m_dat(mdat_a));

  arbiter_rr #(.W(8), .N(3), .Q(1)) dut_b (
    .clk(clk), .rst(rst), .s_stb(stb[2:0]), .s_dat(dat[23:0]), .s_rdy(srdy_b),
    .m_rdy(m_rdy), .m_stb(mstb_b), .m_dat(mdat_b));

  arbiter_rr #(.W(8), .N(4), .Q(4)) dut_c (
    .clk(clk), .rst(rst), .s_stb(stb), .s_dat(dat), .s_rdy(srdy_c),
    .m_rdy(m_rdy), .m_stb(mstb_c), .m_dat(mdat_c));

  typedef struct {
    logic [3:0] stb;
    logic       rdy;
    logic [3:0] srdy;
    logic       mstb;
    logic [9:0] mdat;
  } vec_t;

  vec_t tq[$];

  function automatic vec_t mk(input logic [3:0] s, input logic r, input logic [3:0] sr,
                              input logic ms, input logic [9:0] md);
    vec_t v;
    v.stb = s; v.rdy = r; v.srdy = sr; v.mstb = ms; v.mdat = md;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stb = '0; m_rdy = 1'b0; dat = 32'h13121110;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Each row is one cycle: inputs driven at the falling edge, outputs checked 1ns later.
  task automatic run_table(input int d, input string tag);
    logic [3:0] sr;
    logic       ms;
    logic [9:0] md;
    do_reset();
    for (int r = 0; r < tq.size(); r++) begin
      stb = tq[r].stb; m_rdy = tq[r].rdy;
      #1;
      case (d)
        0:       begin sr = srdy_a;         ms = mstb_a; md = mdat_a; end
        1:       begin sr = {1'b0, srdy_b}; ms = mstb_b; md = mdat_b; end
        default: begin sr = srdy_c;         ms = mstb_c; md = mdat_c; end
      endcase
      $display("%s row %0d: stb=%b m_rdy=%b s_rdy=%b m_stb=%b m_dat=%h",
               tag, r, tq[r].stb, tq[r].rdy, sr, ms, md);
      check($sformatf("%s[%0d].s_rdy", tag, r), 32'(sr), 32'(tq[r].srdy));
      check($sformatf("%s[%0d].m_stb", tag, r), 32'(ms), 32'(tq[r].mstb));
      check($sformatf("%s[%0d].m_dat", tag, r), 32'(md), 32'(tq[r].mdat));
      @(negedge clk);
    end
    tq.delete();
  endtask

  // Reference: owner keeps the grant while strobing and 0 < cnt < q,
  // otherwise the first strobing index after owner (cyclically) wins.
  function automatic int pick(input int n, input int q, input logic [3:0] s,
                              input int owner, input int cnt);
    if (s[owner] && cnt > 0 && cnt < q) return owner;
    for (int k = 1; k <= n; k++) begin
      if (s[(owner + k) % n]) return (owner + k) % n;
    end
    return -1;
  endfunction

  initial begin
    int         m_owner, m_cnt, sel;
    logic       m_stb_m, open;
    logic [9:0] m_dat_m;
    logic [3:0] exp_srdy;

    rst = 1'b1; stb = '0; m_rdy = 1'b0; dat = 32'h13121110;

    // Steady all-request traffic, Q=2: pairs of beats rotating 0,1,2,3,0.
    tq.push_back(mk(4'b1111, 1, 4'b0001, 0, 10'h000));
    tq.push_back(mk(4'b1111, 1, 4'b0001, 1, 10'h010));
    tq.push_back(mk(4'b1111, 1, 4'b0010, 1, 10'h010));
    tq.push_back(mk(4'b1111, 1, 4'b0010, 1, 10'h111));
    tq.push_back(mk(4'b1111, 1, 4'b0100, 1, 10'h111));
    tq.push_back(mk(4'b1111, 1, 4'b0100, 1, 10'h212));
    tq.push_back(mk(4'b1111, 1, 4'b1000, 1, 10'h212));
    tq.push_back(mk(4'b1111, 1, 4'b1000, 1, 10'h313));
    tq.push_back(mk(4'b1111, 1, 4'b0001, 1, 10'h313));
    tq.push_back(mk(4'b1111, 1, 4'b0001, 1, 10'h010));
    run_table(0, "rotate");

    // Lone requester 2 across quantum expiry, then drain with m_dat held.
    tq.push_back(mk(4'b0100, 1, 4'b0100, 0, 10'h000));
    for (int i = 0; i < 5; i++) tq.push_back(mk(4'b0100, 1, 4'b0100, 1, 10'h212));
    tq.push_back(mk(4'b0000, 1, 4'b0000, 1, 10'h212));
    tq.push_back(mk(4'b0000, 1, 4'b0000, 0, 10'h212));
    run_table(0, "lone2");

    // Downstream stall for 3 cycles after the first beat.
    tq.push_back(mk(4'b0011, 1, 4'b0001, 0, 10'h000));
    for (int i = 0; i < 3; i++) tq.push_back(mk(4'b0011, 0, 4'b0000, 1, 10'h010));
    tq.push_back(mk(4'b0011, 1, 4'b0001, 1, 10'h010));
    tq.push_back(mk(4'b0011, 1, 4'b0010, 1, 10'h010));
    tq.push_back(mk(4'b0011, 1, 4'b0010, 1, 10'h111));
    tq.push_back(mk(4'b0011, 1, 4'b0001, 1, 10'h111));
    tq.push_back(mk(4'b0011, 1, 4'b0001, 1, 10'h010));
    tq.push_back(mk(4'b0011, 1, 4'b0010, 1, 10'h010));
    run_table(0, "stall");

    // Q=4: owner 1 drops mid-quantum, 3 takes over, 1 waits for 3's quantum.
    tq.push_back(mk(4'b0010, 1, 4'b0010, 0, 10'h000));
    tq.push_back(mk(4'b0010, 1, 4'b0010, 1, 10'h111));
    tq.push_back(mk(4'b1000, 1, 4'b1000, 1, 10'h111));
    tq.push_back(mk(4'b1010, 1, 4'b1000, 1, 10'h313));
    tq.push_back(mk(4'b1010, 1, 4'b1000, 1, 10'h313));
    tq.push_back(mk(4'b1010, 1, 4'b1000, 1, 10'h313));
    tq.push_back(mk(4'b1010, 1, 4'b0010, 1, 10'h313));
    tq.push_back(mk(4'b0010, 1, 4'b0010, 1, 10'h111));
    run_table(2, "drop");

    // N=3, Q=1: 0 and 2 alternate, wrapping from 2 back to 0.
    tq.push_back(mk(4'b0101, 1, 4'b0001, 0, 10'h000));
    tq.push_back(mk(4'b0101, 1, 4'b0100, 1, 10'h010));
    tq.push_back(mk(4'b0101, 1, 4'b0001, 1, 10'h212));
    tq.push_back(mk(4'b0101, 1, 4'b0100, 1, 10'h010));
    tq.push_back(mk(4'b0101, 1, 4'b0001, 1, 10'h212));
    run_table(1, "wrap");

    // Asynchronous reset while a beat is stalled in the output stage.
    do_reset();
    stb = 4'b1111; m_rdy = 1'b0;
    #1 check("arst.pre_s_rdy", 32'(srdy_a), 32'h1);
    @(negedge clk);
    check("arst.held_m_stb", 32'(mstb_a), 32'h1);
    check("arst.held_m_dat", 32'(mdat_a), 32'h010);
    check("arst.stall_s_rdy", 32'(srdy_a), 32'h0);
    rst = 1'b1;
    #1;
    $display("arst: rst asserted mid-cycle, m_stb=%b s_rdy=%b", mstb_a, srdy_a);
    check("arst.m_stb", 32'(mstb_a), 32'h0);
    check("arst.s_rdy", 32'(srdy_a), 32'h0);
    check("arst.m_dat", 32'(mdat_a), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; stb = 4'b1000; m_rdy = 1'b1;
    #1 check("arst.first_s_rdy", 32'(srdy_a), 32'h8);
    check("arst.first_m_stb", 32'(mstb_a), 32'h0);
    @(negedge clk);
    stb = 4'b1111;
    #1;
    check("arst.beat_m_stb", 32'(mstb_a), 32'h1);
    check("arst.beat_m_dat", 32'(mdat_a), 32'h313);
    check("arst.lock_s_rdy", 32'(srdy_a), 32'h8);

    // Randomized traffic on the N=4, Q=2 instance against the reference.
    do_reset();
    m_owner = 3; m_cnt = 0; m_stb_m = 1'b0; m_dat_m = '0;
    for (int c = 0; c < 400; c++) begin
      stb   = 4'($urandom);
      dat   = $urandom;
      m_rdy = ($urandom_range(0, 3) != 0);
      #1;
      sel  = pick(4, 2, stb, m_owner, m_cnt);
      open = !m_stb_m || m_rdy;
      exp_srdy = (sel >= 0 && open) ? 4'(1 << sel) : 4'b0000;
      check($sformatf("rand[%0d].s_rdy", c), 32'(srdy_a), 32'(exp_srdy));
      check($sformatf("rand[%0d].m_stb", c), 32'(mstb_a), 32'(m_stb_m));
      check($sformatf("rand[%0d].m_dat", c), 32'(mdat_a), 32'(m_dat_m));
      if (sel >= 0 && open) begin
        $display("rand %0d: accept src=%0d dat=%h owner=%0d cnt=%0d",
                 c, sel, dat[sel*8 +: 8], m_owner, m_cnt);
        if (sel == m_owner && stb[m_owner] && m_cnt > 0 && m_cnt < 2) begin
          m_cnt++;
        end else begin
          m_owner = sel;
          m_cnt   = 1;
        end
        m_stb_m = 1'b1;
        m_dat_m = {2'(sel), dat[sel*8 +: 8]};
      end else if (m_stb_m && m_rdy) begin
        m_stb_m = 1'b0;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
Round-robin arbiter with a grant quantum. It shares one downstream stb/rdy stream among N upstream stb/rdy requesters and tags each beat with its source index. The output is registered: one-entry output stage, accept-to-output latency of one cycle. It is the sequencing counterpart to the fixed-priority multiplex block, for paths where fairness is required.

Parameters:
W, 8, data width per requester
N, 2, number of requesters (N >= 2)
Q, 4, grant quantum: max consecutive beats one owner may transfer while others wait (Q >= 1; Q = 1 gives pure round-robin)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
s_stb  input  N  per-requester strobe; bit i = requester i has a beat
s_dat  input  N*W  per-requester data; requester i at bits [i*W +: W]
s_rdy  output  N  per-requester ready; one-hot or zero
m_rdy  input  1  downstream ready
m_stb  output  1  downstream strobe, registered
m_dat  output  $clog2(N)+W  registered {source index, data}; index in upper bits

Behaviour:
- Reset values: m_stb=0, m_dat=0, owner=N-1, cnt=0 (cnt width $clog2(Q+1)). s_rdy=0 while rst is asserted.
- Transfer on either side: a beat moves when stb & rdy are both high at a clock edge.
- Output stage is open when m_stb==0, or when m_stb & m_rdy (drain and refill in the same cycle). Full throughput is 1 beat/cycle.
- Selection (combinational, from s_stb, owner, cnt):
  - lock = s_stb[owner] & (cnt != 0) & (cnt < Q).
  - If lock: sel = owner.
  - Else: sel = first i with s_stb[i], searching owner+1, owner+2, ... cyclically mod N, with owner checked last.
  - valid = |s_stb.
- s_rdy[sel] = valid & open. All other s_rdy bits are 0. s_rdy never asserts for a requester whose s_stb is low.
- On accept (valid & open):
  - m_stb <= 1 and m_dat <= {sel, s_dat[sel*W +: W]}.
  - If sel==owner & lock: cnt <= cnt+1. Otherwise: owner <= sel, cnt <= 1.
- Drain without refill (m_stb & m_rdy & ~valid): m_stb <= 0. m_dat holds its last value.
- Stall (m_stb & ~m_rdy): m_stb and m_dat are held stable, all s_rdy=0, owner and cnt are unchanged.
- Quantum expiry: when cnt==Q, lock drops and the search starts at owner+1. If owner is the only requester, it is re-selected with no bubble and cnt restarts at 1.
- Owner drops s_stb mid-quantum: lock drops that cycle and the grant moves to the next requester in cyclic order, with no bubble.
- Wrap-around: the search after owner=N-1 starts at index 0. First grant after reset goes to the lowest active index.
- Requesters must hold s_stb/s_dat until accepted. The arbiter does not check this; a dropped strobe simply forfeits the grant.
- Reset mid-operation: any held beat is discarded, m_stb drops asynchronously, owner/cnt return to reset values.

Test Plan:
- N=4, W=8, Q=2; s_stb=4'b1111 constant, m_rdy=1, s_dat[i]=8'h10+i -> m_dat source sequence 0,0,1,1,2,2,3,3,0,0... one beat per cycle; first m_stb 1 cycle after rst release plus first accept.
- Q=2; only requester 2 strobing for 6 cycles, m_rdy=1 -> 6 consecutive beats {2'd2, dat}, no bubble at quantum expiry, s_rdy=4'b0100 every cycle.
- Q=2; s_stb=4'b0011, m_rdy low for 3 cycles after the first beat -> m_stb=1 with m_dat={2'd0,8'h10} held stable, s_rdy=0 for those 3 cycles; after m_rdy rises, beats continue 0,1,1,0,0 with no lost or duplicated beat.
- Q=4; requester 1 owns the grant with cnt=2, then drops s_stb while requester 3 strobes -> next accepted beat comes from 3 in that same cycle; requester 1 returning later waits for 3's quantum or for 3 to drop.
- Q=1, N=3; s_stb=3'b101 constant -> alternating sources 0,2,0,2, confirming wrap from index 2 back to 0.
- Assert rst for 1 cycle while m_stb=1 and m_rdy=0 -> m_stb=0 and s_rdy=0 immediately (asynchronous); after release with s_stb=4'b1000, the first beat comes from source 3 with cnt=1.
